// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter_if
// Description : Requester A/B write channels plus register-file write port
//               and busy scoreboard of the register write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_write_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic              a_valid;
  logic              a_ready;
  logic [AW-1:0]     a_addr;
  logic [DW-1:0]     a_data;
  logic              b_valid;
  logic              b_ready;
  logic [AW-1:0]     b_addr;
  logic [DW-1:0]     b_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [2**AW-1:0]  busy;
  logic              grant_b;

  // Requester / register-file side.
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, wr_en, wr_addr, wr_data, busy, grant_b
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, wr_en, wr_addr, wr_data, busy, grant_b
  );
endinterface
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter
// Description : Two per-requester FIFOs (A = ALU writeback, B = load unit)
//               merged round-robin onto one registered register-file write
//               port, with a per-register busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
  parameter int AW    = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  reg_write_arbiter_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_e;

  // Index 0 is requester A, index 1 is requester B.
  logic [AW-1:0]    addr_mem_q [2][DEPTH];
  logic [DW-1:0]    data_mem_q [2][DEPTH];
  logic [PW-1:0]    wptr_q     [2];
  logic [PW-1:0]    rptr_q     [2];
  logic [CW-1:0]    cnt_q      [2];

  rr_e              rr_q, rr_d;
  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [DW-1:0]    wr_data_q;
  logic             grant_b_q;

  logic [AW-1:0]    w_in_addr  [2];
  logic [DW-1:0]    w_in_data  [2];
  logic [1:0]       w_ready;
  logic [1:0]       w_push;
  logic [1:0]       w_head;
  logic [1:0]       w_pop;
  logic             w_grant;
  logic             w_sel;
  logic [2**AW-1:0] w_busy;

  // Requester inputs, readiness from registered occupancy only, and push strobes.
  always_comb begin
    w_in_addr[0] = bus.a_addr;
    w_in_data[0] = bus.a_data;
    w_in_addr[1] = bus.b_addr;
    w_in_data[1] = bus.b_data;
    for (int i = 0; i < 2; i++) begin
      w_ready[i] = !reset && (cnt_q[i] != CW'(DEPTH));
      w_head[i]  = (cnt_q[i] != '0);
    end
    w_push[0] = bus.a_valid & w_ready[0];
    w_push[1] = bus.b_valid & w_ready[1];
  end

  // Round-robin grant: contention goes to the pointer side, pointer then flips.
  always_comb begin
    w_grant = 1'b0;
    w_sel   = 1'b0;
    rr_d    = rr_q;
    if (w_head[0] && w_head[1]) begin
      w_grant = 1'b1;
      w_sel   = (rr_q == RR_B);
    end else if (w_head[0]) begin
      w_grant = 1'b1;
      w_sel   = 1'b0;
    end else if (w_head[1]) begin
      w_grant = 1'b1;
      w_sel   = 1'b1;
    end
    if (w_grant) begin
      rr_d = w_sel ? RR_A : RR_B;
    end
    w_pop[0] = w_grant & ~w_sel;
    w_pop[1] = w_grant &  w_sel;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= RR_A;
    end else begin
      rr_q <= rr_d;
    end
  end

  // FIFO payload storage; contents are only meaningful inside the occupancy window.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) begin
        addr_mem_q[i][wptr_q[i]] <= w_in_addr[i];
        data_mem_q[i][wptr_q[i]] <= w_in_data[i];
      end
    end
  end

  // FIFO pointers wrap naturally (power-of-two depth); count tracks push minus pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) wptr_q[i] <= wptr_q[i] + PW'(1);
        if (w_pop[i])  rptr_q[i] <= rptr_q[i] + PW'(1);
        cnt_q[i] <= cnt_q[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
    end
  end

  // Registered write port: the granted head loads on the edge it pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      grant_b_q <= 1'b0;
    end else begin
      wr_en_q <= w_grant;
      if (w_grant) begin
        wr_addr_q <= addr_mem_q[w_sel][rptr_q[w_sel]];
        wr_data_q <= data_mem_q[w_sel][rptr_q[w_sel]];
        grant_b_q <= w_sel;
      end
    end
  end

  // Busy scoreboard: every live FIFO entry plus the beat currently on wr_*.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) < cnt_q[i]) begin
          w_busy[addr_mem_q[i][rptr_q[i] + PW'(k)]] = 1'b1;
        end
      end
    end
    if (wr_en_q) begin
      w_busy[wr_addr_q] = 1'b1;
    end
    if (reset) begin
      w_busy = '0;
    end
  end

  assign bus.a_ready = w_ready[0];
  assign bus.b_ready = w_ready[1];
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.grant_b = grant_b_q;
  assign bus.busy    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Scoreboard bench for reg_write_arbiter: a queue-level model
//               predicts commits, readiness and busy; a negedge monitor
//               compares against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int NR    = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          gb;
  } commit_t;

  logic clk;
  logic reset;

  reg_write_arbiter_if #(.AW(AW), .DW(DW)) ifc ();

  reg_write_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  ent_t          qa[$];
  ent_t          qb[$];
  bit            m_rr;
  bit            m_infl;
  logic [AW-1:0] m_infl_addr;
  commit_t       exp_q[$];
  logic [DW-1:0] log_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
  endtask

  // Model step: arbitration on the pre-edge queue contents, then accept pushes.
  always @(posedge clk) begin
    bit ra, rb, g, side;
    ent_t e;
    if (reset) begin
      qa.delete();
      qb.delete();
      exp_q.delete();
      m_rr   = 1'b0;
      m_infl = 1'b0;
    end else begin
      ra = (qa.size() < DEPTH);
      rb = (qb.size() < DEPTH);
      g = 1'b0;
      side = 1'b0;
      if (qa.size() > 0 && qb.size() > 0) begin g = 1'b1; side = m_rr; end
      else if (qa.size() > 0)             begin g = 1'b1; side = 1'b0; end
      else if (qb.size() > 0)             begin g = 1'b1; side = 1'b1; end
      m_infl = g;
      if (g) begin
        e = side ? qb.pop_front() : qa.pop_front();
        exp_q.push_back('{addr: e.addr, data: e.data, gb: side});
        m_infl_addr = e.addr;
        m_rr = ~side;
      end
      if (ifc.a_valid && ra) qa.push_back('{addr: ifc.a_addr, data: ifc.a_data});
      if (ifc.b_valid && rb) qb.push_back('{addr: ifc.b_addr, data: ifc.b_data});
    end
  end

  // Monitor: compare readiness, busy and any presented write beat.
  always @(negedge clk) begin
    logic [NR-1:0] eb;
    commit_t c;
    eb = '0;
    foreach (qa[i]) eb[qa[i].addr] = 1'b1;
    foreach (qb[i]) eb[qb[i].addr] = 1'b1;
    if (m_infl) eb[m_infl_addr] = 1'b1;
    check(ifc.a_ready === (!reset && qa.size() < DEPTH), "a_ready",
          32'(ifc.a_ready), 32'(!reset && qa.size() < DEPTH));
    check(ifc.b_ready === (!reset && qb.size() < DEPTH), "b_ready",
          32'(ifc.b_ready), 32'(!reset && qb.size() < DEPTH));
    check(ifc.busy === eb, "busy", 32'(ifc.busy), 32'(eb));
    if (ifc.wr_en === 1'b1) begin
      log_q.push_back(ifc.wr_data);
      check(exp_q.size() > 0, "wr_unexpected", 32'(ifc.wr_data), 32'(exp_q.size()));
      if (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        check(ifc.wr_addr === c.addr, "wr_addr", 32'(ifc.wr_addr), 32'(c.addr));
        check(ifc.wr_data === c.data, "wr_data", 32'(ifc.wr_data), 32'(c.data));
        check(ifc.grant_b === c.gb, "grant_b", 32'(ifc.grant_b), 32'(c.gb));
      end
    end else begin
      check(ifc.wr_en === 1'b0 && exp_q.size() == 0, "wr_missing",
            32'(ifc.wr_en), 32'(exp_q.size()));
      exp_q.delete();
    end
    if (reset) begin
      check(ifc.wr_addr === '0 && ifc.wr_data === '0 && ifc.grant_b === 1'b0,
            "reset_outputs", {ifc.wr_addr, ifc.wr_data, ifc.grant_b}, 32'd0);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ifc.a_valid = 1'b0;
    ifc.b_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Handshake-aware burst: each side offers consecutive data until accepted.
  task automatic stream(input int na, input int nb,
                        input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                        input logic [DW-1:0] da, input logic [DW-1:0] db);
    int ai, bi, guard;
    bit acc_a, acc_b;
    ai = 0; bi = 0; guard = 0;
    while ((ai < na || bi < nb) && guard < 200) begin
      ifc.a_valid = (ai < na);
      ifc.a_addr  = aa;
      ifc.a_data  = da + DW'(ai);
      ifc.b_valid = (bi < nb);
      ifc.b_addr  = ba;
      ifc.b_data  = db + DW'(bi);
      acc_a = ifc.a_valid && ifc.a_ready;
      acc_b = ifc.b_valid && ifc.b_ready;
      tick();
      if (acc_a) ai++;
      if (acc_b) bi++;
      guard++;
    end
    ifc.a_valid = 1'b0;
    ifc.b_valid = 1'b0;
    check(guard < 200, "stream_timeout", 32'(guard), 32'd200);
  endtask

  initial begin
    logic [DW-1:0] want[$];
    reset = 1'b1;
    ifc.a_valid = 1'b0; ifc.a_addr = '0; ifc.a_data = '0;
    ifc.b_valid = 1'b0; ifc.b_addr = '0; ifc.b_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Contention straight after reset (pointer at A): strict A/B alternation.
    log_q.delete();
    stream(4, 4, AW'(1), AW'(2), 8'h10, 8'h20);
    idle(12);
    want = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
    check(log_q.size() == want.size(), "contention_count", 32'(log_q.size()), 32'(want.size()));
    foreach (want[i]) begin
      if (i < log_q.size())
        check(log_q[i] === want[i], "contention_order", 32'(log_q[i]), 32'(want[i]));
    end

    // Same-address race with the pointer back at A.
    log_q.delete();
    ifc.a_valid = 1'b1; ifc.a_addr = AW'(5); ifc.a_data = 8'h11;
    ifc.b_valid = 1'b1; ifc.b_addr = AW'(5); ifc.b_data = 8'h22;
    tick();
    idle(6);
    check(log_q.size() == 2, "race_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check(log_q[0] === 8'h11, "race_first", 32'(log_q[0]), 32'h11);
      check(log_q[1] === 8'h22, "race_second", 32'(log_q[1]), 32'h22);
    end

    // Single write from A.
    log_q.delete();
    ifc.a_valid = 1'b1; ifc.a_addr = AW'(3); ifc.a_data = 8'h5A;
    tick();
    idle(5);
    check(log_q.size() == 1 && log_q[0] === 8'h5A, "single_write",
          32'(log_q.size()), 32'd1);

    // Backpressure on B while A keeps its queue saturated.
    log_q.delete();
    stream(6, 3, AW'(9), AW'(10), 8'h40, 8'h60);
    idle(10);
    check(log_q.size() == 9, "backpressure_count", 32'(log_q.size()), 32'd9);

    // Reset mid-stream discards queued writes; then an idle stretch.
    ifc.a_valid = 1'b1; ifc.a_addr = AW'(7); ifc.a_data = 8'h31;
    ifc.b_valid = 1'b1; ifc.b_addr = AW'(8); ifc.b_data = 8'h41;
    tick();
    ifc.a_data = 8'h32;
    ifc.b_valid = 1'b0;
    tick();
    ifc.a_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    log_q.delete();
    idle(10);
    check(log_q.size() == 0, "post_reset_idle", 32'(log_q.size()), 32'd0);

    // Randomized traffic with occasional resets; a small address range forces overlaps.
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 63) == 0);
      ifc.a_valid = ($urandom_range(0, 3) != 0);
      ifc.a_addr  = AW'($urandom_range(0, 3));
      ifc.a_data  = DW'($urandom);
      ifc.b_valid = ($urandom_range(0, 2) != 0);
      ifc.b_addr  = AW'($urandom_range(0, 5));
      ifc.b_data  = DW'($urandom);
      tick();
    end
    reset = 1'b0;
    idle(10);
    check(exp_q.size() == 0 && qa.size() == 0 && qb.size() == 0, "drained",
          32'(exp_q.size() + qa.size() + qb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
